// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int          WORD_W           = 32;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc_plus4;
        logic              valid;
    } ifid_t;

    // Forces word alignment on any address headed for the PC.
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
        return a & ~(WORD_W'(3));
    endfunction

endpackage

// File: rtl/fetch_stage_program_counter.sv
// PC register: synchronous reset to RESET_PC, load enable, always word aligned.
module program_counter
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load,
    input  logic [WORD_W-1:0] NextPc,
    output logic [WORD_W-1:0] Pc
);

    always_ff @(posedge Clk) begin
        if (Reset)
            Pc <= word_align(RESET_PC);
        else if (Load)
            Pc <= word_align(NextPc);
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: BOOT/RUN/HALTED control, PC sequencing and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Redirect,
    input  logic [WORD_W-1:0] RedirectTarget,
    input  logic              Halt,
    output logic [WORD_W-1:0] InstrAddress,
    input  logic [WORD_W-1:0] Instruction,
    output logic [WORD_W-1:0] IFID_Instruction,
    output logic [WORD_W-1:0] IFID_PCPlus4,
    output logic              IFID_Valid,
    output logic [1:0]        FetchState
);

    fetch_state_t      state, state_next;
    logic [WORD_W-1:0] pc, pc_plus4, pc_next;
    logic              pc_load;
    ifid_t             ifid, ifid_next;
    logic              ifid_load;

    program_counter #(.RESET_PC(RESET_PC)) u_pc (
        .Clk    (Clk),
        .Reset  (Reset),
        .Load   (pc_load),
        .NextPc (pc_next),
        .Pc     (pc)
    );

    // Modulo-2^32 increment: 0xFFFF_FFFC rolls over to 0.
    assign pc_plus4 = pc + WORD_W'(4);

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= BOOT;
        else
            state <= state_next;
    end

    // A flush (boot, halt, redirect) leaves PCPlus4 as-is; only instr/valid are meaningful.
    always_comb begin
        state_next         = state;
        pc_load            = 1'b0;
        pc_next            = pc_plus4;
        ifid_load          = 1'b0;
        ifid_next.instr    = NOP_WORD;
        ifid_next.pc_plus4 = ifid.pc_plus4;
        ifid_next.valid    = 1'b0;
        case (state)
            BOOT: begin
                state_next = RUN;
                ifid_load  = 1'b1;
            end
            RUN: begin
                if (Halt) begin
                    state_next = HALTED;
                    ifid_load  = 1'b1;
                end else if (Redirect) begin
                    pc_load   = 1'b1;
                    pc_next   = RedirectTarget;
                    ifid_load = 1'b1;
                end else if (!Stall) begin
                    pc_load            = 1'b1;
                    ifid_load          = 1'b1;
                    ifid_next.instr    = Instruction;
                    ifid_next.pc_plus4 = pc_plus4;
                    ifid_next.valid    = 1'b1;
                end
            end
            HALTED: ;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ifid.instr    <= NOP_WORD;
            ifid.pc_plus4 <= '0;
            ifid.valid    <= 1'b0;
        end else if (ifid_load) begin
            ifid <= ifid_next;
        end
    end

    assign InstrAddress     = pc;
    assign IFID_Instruction = ifid.instr;
    assign IFID_PCPlus4     = ifid.pc_plus4;
    assign IFID_Valid       = ifid.valid;
    assign FetchState       = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle model compare plus directed literal checks.
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset, Stall, Redirect, Halt;
    logic [31:0] RedirectTarget;
    logic [31:0] InstrAddress, Instruction;
    logic [31:0] IFID_Instruction, IFID_PCPlus4;
    logic        IFID_Valid;
    logic [1:0]  FetchState;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    fetch_stage dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Stall            (Stall),
        .Redirect         (Redirect),
        .RedirectTarget   (RedirectTarget),
        .Halt             (Halt),
        .InstrAddress     (InstrAddress),
        .Instruction      (Instruction),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid),
        .FetchState       (FetchState)
    );

    always #5 Clk = ~Clk;

    // Instruction memory: word i holds i*3 (32-bit truncated).
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a >> 2) * 32'd3;
    endfunction

    assign Instruction = mem(InstrAddress);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state is 0 boot, 1 run, 2 halted.
    int          m_state;
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;

    always @(posedge Clk) begin
        if (Reset) begin
            m_state <= 0; m_pc <= 32'h0; m_instr <= NOP; m_pc4 <= 32'h0; m_valid <= 1'b0;
        end else if (m_state == 0) begin
            m_state <= 1; m_instr <= NOP; m_valid <= 1'b0;
        end else if (m_state == 1) begin
            if (Halt) begin
                m_state <= 2; m_instr <= NOP; m_valid <= 1'b0;
            end else if (Redirect) begin
                m_pc <= {RedirectTarget[31:2], 2'b00}; m_instr <= NOP; m_valid <= 1'b0;
            end else if (!Stall) begin
                m_instr <= mem(m_pc); m_pc4 <= m_pc + 32'd4; m_pc <= m_pc + 32'd4; m_valid <= 1'b1;
            end
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("m_addr",  InstrAddress,             m_pc);
            chk("m_state", {30'd0, FetchState},      m_state[31:0]);
            chk("m_valid", {31'd0, IFID_Valid},      {31'd0, m_valid});
            chk("m_instr", IFID_Instruction,         m_instr);
            if (m_valid) chk("m_pc4", IFID_PCPlus4, m_pc4);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_if(input string tag, input logic [31:0] pc, input logic [1:0] st,
                             input logic [31:0] ins, input logic [31:0] p4, input logic v);
        chk({tag, "_pc"},    InstrAddress, pc);
        chk({tag, "_state"}, {30'd0, FetchState}, {30'd0, st});
        chk({tag, "_valid"}, {31'd0, IFID_Valid}, {31'd0, v});
        chk({tag, "_instr"}, IFID_Instruction, ins);
        if (v || tag == "rst") chk({tag, "_pc4"}, IFID_PCPlus4, p4);
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; Halt = 1'b0; RedirectTarget = 32'h0;
        step(); step();
        cmp_en = 1'b1;
        expect_if("rst", 32'h0, 2'd0, NOP, 32'h0, 1'b0);

        // Straight-line fetch: 0,3,6,9 from the second edge after reset.
        Reset = 1'b0;
        step(); expect_if("boot", 32'h0, 2'd1, NOP, 32'h0, 1'b0);
        step(); expect_if("seq0", 32'h4,  2'd1, 32'd0, 32'd4,  1'b1);
        step(); expect_if("seq1", 32'h8,  2'd1, 32'd3, 32'd8,  1'b1);
        step(); expect_if("seq2", 32'hC,  2'd1, 32'd6, 32'd12, 1'b1);
        step(); expect_if("seq3", 32'h10, 2'd1, 32'd9, 32'd16, 1'b1);

        // Reset with stall and redirect pending wins over both.
        Reset = 1'b1; Stall = 1'b1; Redirect = 1'b1; RedirectTarget = 32'h100;
        step(); expect_if("rst", 32'h0, 2'd0, NOP, 32'h0, 1'b0);
        Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0;
        step(); step(); step();
        expect_if("pre_stall", 32'h8, 2'd1, 32'd3, 32'd8, 1'b1);

        // Stall three cycles at PC=8.
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); expect_if("stall", 32'h8, 2'd1, 32'd3, 32'd8, 1'b1);
        end
        Stall = 1'b0;
        step(); expect_if("resume", 32'hC, 2'd1, 32'd6, 32'd12, 1'b1);

        // Redirect beats stall; target low bits dropped.
        Redirect = 1'b1; Stall = 1'b1; RedirectTarget = 32'h0000_0043;
        step(); expect_if("redir", 32'h40, 2'd1, NOP, 32'h0, 1'b0);
        Redirect = 1'b0; Stall = 1'b0;
        step(); expect_if("post_redir", 32'h44, 2'd1, 32'd48, 32'h44, 1'b1);

        // PC wrap at the top of the address space.
        Redirect = 1'b1; RedirectTarget = 32'hFFFF_FFFC;
        step(); expect_if("to_top", 32'hFFFF_FFFC, 2'd1, NOP, 32'h0, 1'b0);
        Redirect = 1'b0;
        step(); expect_if("wrap", 32'h0, 2'd1, 32'hBFFF_FFFD, 32'h0, 1'b1);

        // Run to PC=20, then halt; everything else ignored.
        for (int i = 0; i < 5; i++) step();
        chk("at20", InstrAddress, 32'd20);
        Halt = 1'b1;
        step(); expect_if("halt", 32'd20, 2'd2, NOP, 32'h0, 1'b0);
        Halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            Redirect = i[0]; Stall = ~i[0]; RedirectTarget = 32'h200;
            step(); expect_if("halted", 32'd20, 2'd2, NOP, 32'h0, 1'b0);
        end

        Reset = 1'b1; Redirect = 1'b1;
        step(); expect_if("rst", 32'h0, 2'd0, NOP, 32'h0, 1'b0);
        Reset = 1'b0; Redirect = 1'b0; Stall = 1'b0;
        step(); step(); expect_if("restart", 32'h4, 2'd1, 32'd0, 32'd4, 1'b1);

        @(negedge Clk);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on Reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000: instruction word injected into IF/ID on bubble or flush.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Stall  input  1  hazard-unit hold request; freezes PC and IF/ID.
REQ-006 Redirect  input  1  taken branch or jump resolved downstream.
REQ-007 RedirectTarget  input  32  next-PC value when Redirect=1.
REQ-008 Halt  input  1  stop fetching; sticky until Reset.
REQ-009 InstrAddress  output  32  byte address driven to instruction memory (combinational read).
REQ-010 Instruction  input  32  word returned by instruction memory for InstrAddress, same cycle.
REQ-011 IFID_Instruction  output  32  registered instruction to decode.
REQ-012 IFID_PCPlus4  output  32  registered PC+4 of that instruction.
REQ-013 IFID_Valid  output  1  IF/ID holds a real instruction.
REQ-014 FetchState  output  2  current FSM state, for debug.

Function
REQ-015 InstrAddress SHALL equal the PC register; the combinational path from PC to InstrAddress SHALL NOT add any register.
REQ-016 The FSM SHALL have three states: BOOT=2'd0, RUN=2'd1, HALTED=2'd2.
REQ-017 BOOT: PC held at RESET_PC; IF/ID loaded with NOP_WORD, Valid=0; unconditional transition to RUN on the next edge.
REQ-018 RUN, priority per edge: Halt > Redirect > Stall > sequential.
REQ-019 RUN with Halt=1: transition to HALTED; PC held; IF/ID loaded with NOP_WORD, Valid=0.
REQ-020 RUN with Redirect=1: PC <= {RedirectTarget[31:2],2'b00}; IF/ID loaded with NOP_WORD, Valid=0 (flush), even if Stall=1.
REQ-021 RUN with Stall=1 and Redirect=0: PC and all IF/ID outputs hold their values.
REQ-022 RUN with neither: PC <= PC+4; IF/ID_Instruction <= Instruction, IFID_PCPlus4 <= PC+4, Valid=1.
REQ-023 PC+4 SHALL use 32-bit modulo arithmetic; 32'hFFFF_FFFC wraps to 32'h0000_0000 without error.
REQ-024 PC[1:0] SHALL always be 2'b00.
REQ-025 HALTED: PC and IF/ID frozen with Valid=0; Stall, Redirect and Halt ignored; exit only via Reset.
REQ-026 Fetch latency: instruction at address A appears on IFID_Instruction one edge after PC=A in RUN without stall.

Reset
REQ-027 On Reset=1 at an edge: PC=RESET_PC, state=BOOT, IFID_Instruction=NOP_WORD, IFID_PCPlus4=32'h0, IFID_Valid=0, regardless of any other input.
REQ-028 Reset asserted mid-stall, mid-redirect or in HALTED SHALL behave identically to REQ-027.
REQ-029 First valid instruction (address RESET_PC) SHALL appear in IF/ID on the second edge after Reset deasserts.

Structure
REQ-030 Shared package SHALL hold the state encodings BOOT/RUN/HALTED, NOP_WORD default and the 32-bit word-width constant.
REQ-031 One sub-module, program_counter (PC register with load enable and synchronous reset), SHALL hold the PC; the FSM and IF/ID register live in fetch_stage.

Verification
REQ-032 Reset, memory word i = i*3, no stall -> IFID_Instruction sequence 0,3,6,9 with IFID_PCPlus4 4,8,12,16, Valid=1 from second post-reset edge.
REQ-033 Stall for 3 cycles at PC=8 -> InstrAddress stays 8, IF/ID output unchanged for 3 cycles, then resumes with word 2 (value 6).
REQ-034 Redirect=1, Stall=1, RedirectTarget=32'h0000_0043 at PC=12 -> next PC=32'h40, IF/ID=NOP_WORD, Valid=0; next edge IF/ID=word 16 (value 48).
REQ-035 PC forced to 32'hFFFF_FFFC via redirect, no stall -> next PC=32'h0, IFID_PCPlus4=32'h0.
REQ-036 Halt at PC=20 then Redirect and Stall toggled -> FetchState=2, PC=20, Valid=0 held; Reset -> PC=0, FetchState=0.
